div_int: RTL and testbench
==========================

DIV_INT -- requirements
Module: div_int

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, 8..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands and in_signed valid.
REQ-005 SHALL have port in_ready, output, 1, divider can accept a new operation.
REQ-006 SHALL have port in_signed, input, 1, 1 selects two's-complement division, 0 selects unsigned.
REQ-007 SHALL have port dividend, input, WIDTH, numerator.
REQ-008 SHALL have port divisor, input, WIDTH, denominator.
REQ-009 SHALL have port out_valid, output, 1, quotient and remainder valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port quotient, output, WIDTH, result quotient, truncated toward zero.
REQ-012 SHALL have port remainder, output, WIDTH, result remainder; its sign follows the dividend.
REQ-013 SHALL have port div_zero, output, 1, the current result came from a zero divisor.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; an operation is accepted when in_valid && in_ready.
REQ-016 On acceptance with a nonzero divisor and no signed overflow, SHALL capture |dividend| and |divisor| (magnitudes only when in_signed=1), record both operand signs, clear the step counter, and go to CALC.
REQ-017 In CALC, SHALL perform one restoring radix-2 step per cycle for exactly WIDTH cycles, producing one quotient bit per cycle, MSB first.
REQ-018 Each step SHALL shift {partial_remainder, dividend_shift} left by 1, trial-subtract the divisor in a WIDTH+1-bit adder, keep the difference if it is non-negative, and set the quotient bit to 1 in that case.
REQ-019 After the last step, SHALL negate the quotient if the operand signs differ (signed only), negate the remainder if the dividend was negative (signed only), then go to DONE.
REQ-020 SHALL assert out_valid in DONE only; the accepting cycle counts as cycle 0, and out_valid SHALL first be high in cycle WIDTH+1.
REQ-021 Divide-by-zero: SHALL go directly to DONE with quotient = all ones, remainder = the original dividend, and div_zero=1, with out_valid high in cycle 1.
REQ-022 Signed overflow (in_signed=1, dividend = most negative value, divisor = -1): SHALL go directly to DONE with quotient = dividend, remainder = 0, and div_zero=0, with out_valid high in cycle 1.
REQ-023 While out_valid && !out_ready, SHALL hold quotient, remainder and div_zero stable.
REQ-024 On out_valid && out_ready, SHALL return to IDLE; in_ready SHALL rise in the following cycle (no same-cycle accept from DONE).
REQ-025 SHALL ignore changes on in_valid and the operand inputs while in CALC or DONE.
REQ-026 The step counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-027 While rst_n=0, SHALL hold the FSM in IDLE with in_ready=1, out_valid=0, and quotient, remainder, div_zero and all internal registers at 0, regardless of the clock.
REQ-028 A reset asserted mid-CALC or mid-DONE SHALL abort the operation with no result delivered; the first cycle after release SHALL be IDLE.

Structure
REQ-029 Package arith_int_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the default WIDTH constant, shared with the mul_int blocks.
REQ-030 One combinational sub-module, div_int_step, SHALL implement a single restoring step: inputs are the partial remainder, the incoming dividend bit and the divisor; outputs are the next remainder and the quotient bit.
REQ-031 Total RTL size SHALL be 120-400 lines.

Verification
REQ-032 Unsigned 100/7 (WIDTH=32) -> quotient=14, remainder=2, out_valid high in cycle 33.
REQ-033 Signed -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); signed 100/-7 -> quotient=-14, remainder=2.
REQ-034 Divisor=0 with dividend=0x1234 -> quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1, out_valid in cycle 1.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0, out_valid in cycle 1; the same operands unsigned -> quotient=0, remainder=0x80000000 after 33 cycles.
REQ-036 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; in_ready=1 in the cycle after the handshake.
REQ-037 Reset pulse at CALC cycle 10 -> out_valid never asserts, in_ready=1 after release, and a following 9/3 operation returns quotient=3, remainder=0.

Source files
------------

// File: rtl/arith_int_pkg.sv
// Shared definitions for the integer arithmetic blocks (div_int, mul_int).
//   DefaultWidth  : default operand/result width in bits
//   arith_state_e : IDLE / CALC / DONE handshake FSM states
package arith_int_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } arith_state_e;

endpackage

// File: rtl/div_int_step.sv
// One restoring radix-2 division step (purely combinational).
//   rem_i     : partial remainder entering the step (always < divisor_i)
//   bit_i     : next dividend bit, shifted in at the LSB
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder leaving the step
//   q_o       : quotient bit produced by this step
module div_int_step
  import arith_int_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    // shifted < 2*divisor, so a successful subtraction always leaves diff < 2^WIDTH;
    // the top bit of the WIDTH+1-bit difference is therefore a clean borrow flag.
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_int.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   in_signed            : 1 = two's-complement, 0 = unsigned
//   dividend, divisor    : operands
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   quotient, remainder  : truncated-toward-zero quotient, remainder signed like dividend
//   div_zero             : result came from a zero divisor
module div_int
  import arith_int_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  arith_state_e    state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] shift_q, shift_d;  // dividend bits out at MSB, quotient bits in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             sgn_ovf;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_raw;

  div_int_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (shift_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_comb begin
    dvd_abs = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs = (in_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    sgn_ovf = in_signed && (dividend == MinNeg) && (divisor == '1);
    quo_raw = {shift_q[WIDTH-2:0], step_q};

    state_d   = state_q;
    rem_d     = rem_q;
    shift_d   = shift_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    remo_d    = remo_q;
    dz_d      = dz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quo_d   = '1;
            remo_d  = dividend;
            dz_d    = 1'b1;
            state_d = StDone;
          end else if (sgn_ovf) begin
            quo_d   = dividend;
            remo_d  = '0;
            dz_d    = 1'b0;
            state_d = StDone;
          end else begin
            rem_d     = '0;
            shift_d   = dvd_abs;
            dvs_d     = dvs_abs;
            cnt_d     = '0;
            neg_quo_d = in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = in_signed && dividend[WIDTH-1];
            dz_d      = 1'b0;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d   = step_rem;
        shift_d = quo_raw;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          quo_d   = neg_quo_q ? -quo_raw : quo_raw;
          remo_d  = neg_rem_q ? -step_rem : step_rem;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      shift_q   <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      remo_q    <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      shift_q   <= shift_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      remo_q    <= remo_d;
      dz_q      <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_int.sv
// Directed-vector bench for div_int (WIDTH = 32).
module tb_div_int;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_int #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_signed(in_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the inputs while busy, optionally stall the result.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat, input int hold);
    int t;
    int cyc;
    logic [W-1:0] q0, r0;
    logic dz0;
    n_vec++;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " in_ready before accept"}, W'(in_ready), W'(1));
    in_valid  = 1'b1;
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_signed = ~sgn;
    dividend  = 32'hA5A5_A5A5;
    divisor   = '0;
    cyc = 1;
    while (cyc <= 100) begin
      @(negedge clk);
      if (out_valid) break;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, W'(cyc), W'(elat));
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_zero"}, W'(div_zero), W'(edz));
    chk({tag, " in_ready in DONE"}, W'(in_ready), W'(0));
    q0  = quotient;
    r0  = remainder;
    dz0 = div_zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " stall quotient"}, quotient, q0);
      chk({tag, " stall remainder"}, remainder, r0);
      chk({tag, " stall div_zero"}, W'(div_zero), W'(dz0));
      chk({tag, " stall out_valid"}, W'(out_valid), W'(1));
      chk({tag, " stall in_ready"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " in_ready after handshake"}, W'(in_ready), W'(1));
    chk({tag, " out_valid after handshake"}, W'(out_valid), W'(0));
  endtask

  initial begin
    int  t;
    logic seen;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33};
    vecs[3]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33};
    vecs[4]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 33};
    vecs[9]  = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 33};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
    vecs[11] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1};
    vecs[12] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 33};
    vecs[13] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[14] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset quotient", quotient, '0);
    chk("reset remainder", remainder, '0);
    chk("reset div_zero", W'(div_zero), W'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             vecs[i].dz, vecs[i].lat, 0);
    end

    // Back-pressure in DONE for 5 cycles.
    run_op("stall", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 5);

    // Reset pulse in the middle of CALC aborts the operation.
    n_vec++;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_valid  = 1'b1;
    in_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready in reset", W'(in_ready), W'(1));
    chk("abort out_valid in reset", W'(out_valid), W'(0));
    chk("abort quotient in reset", quotient, '0);
    chk("abort remainder in reset", remainder, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort in_ready after release", W'(in_ready), W'(1));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort no out_valid", W'(seen), W'(0));
    run_op("post-abort 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
